// File: rtl/etapa_escritura_estado_pkg.sv
// Shared opcode encoding, status-flag bit positions and default widths for the
// execute/writeback stage that follows the 16-bit ALSU.
package etapa_escritura_estado_pkg;

    localparam int ANCHO_DEF     = 16;
    localparam int ANCHO_DIR_DEF = 3;

    // Same encoding as the ALSU Selector input
    typedef enum logic [3:0] {
        OP_NOT  = 4'b0000,
        OP_AND  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_DEC  = 4'b0100,
        OP_ADD  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_INC  = 4'b0111,
        OP_MOV  = 4'b1000,
        OP_RLC  = 4'b1001,
        OP_TEST = 4'b1010,
        OP_RRC  = 4'b1011,
        OP_SL   = 4'b1100,
        OP_SR   = 4'b1101,
        OP_RL   = 4'b1110,
        OP_RR   = 4'b1111
    } opcode_e;

    // Estado = {N, Z, V, C}
    localparam int IDX_N = 3;
    localparam int IDX_Z = 2;
    localparam int IDX_V = 1;
    localparam int IDX_C = 0;

endpackage

// File: rtl/etapa_escritura_estado_banderas.sv
// Next status-register value from the opcode, operands, final result and the
// current flags; purely combinational.
module calculo_banderas
    import etapa_escritura_estado_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [3:0]       Selector,
    input  logic [ANCHO-1:0] OperandoA,
    input  logic [ANCHO-1:0] OperandoB,
    input  logic [ANCHO-1:0] R,
    input  logic             AcarreoAlsu,
    input  logic [3:0]       Estado,
    output logic [3:0]       EstadoSiguiente
);

    logic a_msb, b_msb, r_msb;

    always_comb begin
        a_msb = OperandoA[ANCHO-1];
        b_msb = OperandoB[ANCHO-1];
        r_msb = R[ANCHO-1];

        EstadoSiguiente        = Estado;
        EstadoSiguiente[IDX_Z] = (R == '0);
        EstadoSiguiente[IDX_N] = r_msb;

        // AcarreoAlsu may float for logic/MOV, so it is only read in the arms below
        case (opcode_e'(Selector))
            OP_ADD: begin
                EstadoSiguiente[IDX_C] = AcarreoAlsu;
                EstadoSiguiente[IDX_V] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB, OP_TEST: begin
                EstadoSiguiente[IDX_C] = AcarreoAlsu;
                EstadoSiguiente[IDX_V] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_INC: begin
                EstadoSiguiente[IDX_C] = AcarreoAlsu;
                EstadoSiguiente[IDX_V] = (OperandoA == {1'b0, {(ANCHO-1){1'b1}}});
            end
            OP_DEC: begin
                EstadoSiguiente[IDX_C] = AcarreoAlsu;
                EstadoSiguiente[IDX_V] = (OperandoA == {1'b1, {(ANCHO-1){1'b0}}});
            end
            OP_RLC: EstadoSiguiente[IDX_C] = OperandoA[ANCHO-1];
            OP_RRC: EstadoSiguiente[IDX_C] = OperandoA[0];
            OP_SL, OP_SR, OP_RL, OP_RR: EstadoSiguiente[IDX_C] = AcarreoAlsu;
            default: ;
        endcase
    end

endmodule

// File: rtl/etapa_escritura_estado.sv
// Execute/writeback stage: rotate-through-carry mux, status register and a
// single-entry register-bank write request with valid/ready handshake.
module etapa_escritura_estado
    import etapa_escritura_estado_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int ANCHO_DIR = ANCHO_DIR_DEF
) (
    input  logic                 Reloj,
    input  logic                 Reinicio,
    input  logic                 EntradaValida,
    output logic                 EntradaLista,
    input  logic [3:0]           Selector,
    input  logic [ANCHO-1:0]     OperandoA,
    input  logic [ANCHO-1:0]     OperandoB,
    input  logic [ANCHO-1:0]     ResultadoAlsu,
    input  logic                 AcarreoAlsu,
    input  logic [ANCHO_DIR-1:0] Destino,
    output logic                 EscrituraValida,
    input  logic                 EscrituraLista,
    output logic [ANCHO_DIR-1:0] EscrituraDir,
    output logic [ANCHO-1:0]     EscrituraDato,
    output logic [3:0]           Estado
);

    logic [ANCHO-1:0] resultado;
    logic [3:0]       estado_sig;
    logic             acepta;
    logic             escribe;

    assign EntradaLista = !EscrituraValida || EscrituraLista;
    assign acepta       = EntradaValida && EntradaLista;
    assign escribe      = (Selector != OP_TEST);

    // Rotates through carry use the registered C, not the ALSU output
    always_comb begin
        resultado = ResultadoAlsu;
        if (Selector == OP_RLC)
            resultado = {OperandoA[ANCHO-2:0], Estado[IDX_C]};
        else if (Selector == OP_RRC)
            resultado = {Estado[IDX_C], OperandoA[ANCHO-1:1]};
    end

    calculo_banderas #(
        .ANCHO (ANCHO)
    ) u_banderas (
        .Selector        (Selector),
        .OperandoA       (OperandoA),
        .OperandoB       (OperandoB),
        .R               (resultado),
        .AcarreoAlsu     (AcarreoAlsu),
        .Estado          (Estado),
        .EstadoSiguiente (estado_sig)
    );

    // Flags commit at acceptance; the write entry is replaced in place when a
    // drain and an accept coincide, keeping EscrituraValida high.
    always_ff @(posedge Reloj) begin
        if (Reinicio) begin
            Estado          <= '0;
            EscrituraValida <= 1'b0;
            EscrituraDir    <= '0;
            EscrituraDato   <= '0;
        end else if (acepta) begin
            Estado <= estado_sig;
            if (escribe) begin
                EscrituraValida <= 1'b1;
                EscrituraDir    <= Destino;
                EscrituraDato   <= resultado;
            end else if (EscrituraLista) begin
                EscrituraValida <= 1'b0;
            end
        end else if (EscrituraLista) begin
            EscrituraValida <= 1'b0;
        end
    end

endmodule

// File: tb/tb_etapa_escritura_estado.sv
// Bench for etapa_escritura_estado: vector table for flags/results plus a
// write scoreboard checked on every register-bank drain.
module tb_etapa_escritura_estado;
    import etapa_escritura_estado_pkg::*;

    logic        Reloj = 1'b0;
    logic        Reinicio;
    logic        EntradaValida;
    logic        EntradaLista;
    logic [3:0]  Selector;
    logic [15:0] OperandoA, OperandoB, ResultadoAlsu;
    logic        AcarreoAlsu;
    logic [2:0]  Destino;
    logic        EscrituraValida;
    logic        EscrituraLista;
    logic [2:0]  EscrituraDir;
    logic [15:0] EscrituraDato;
    logic [3:0]  Estado;

    etapa_escritura_estado #(
        .ANCHO     (16),
        .ANCHO_DIR (3)
    ) dut (
        .Reloj           (Reloj),
        .Reinicio        (Reinicio),
        .EntradaValida   (EntradaValida),
        .EntradaLista    (EntradaLista),
        .Selector        (Selector),
        .OperandoA       (OperandoA),
        .OperandoB       (OperandoB),
        .ResultadoAlsu   (ResultadoAlsu),
        .AcarreoAlsu     (AcarreoAlsu),
        .Destino         (Destino),
        .EscrituraValida (EscrituraValida),
        .EscrituraLista  (EscrituraLista),
        .EscrituraDir    (EscrituraDir),
        .EscrituraDato   (EscrituraDato),
        .Estado          (Estado)
    );

    always #5 Reloj = ~Reloj;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] a, b, r;
        logic        cy;
        logic [2:0]  dst;
        logic [3:0]  est;
        logic        wr;
        logic [15:0] dato;
    } vec_t;

    typedef struct {
        logic [2:0]  dir;
        logic [15:0] dato;
    } esc_t;

    esc_t esperadas[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    task automatic conducir(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] r, input logic cy, input logic [2:0] dst);
        EntradaValida = 1'b1;
        Selector      = sel;
        OperandoA     = a;
        OperandoB     = b;
        ResultadoAlsu = r;
        AcarreoAlsu   = cy;
        Destino       = dst;
    endtask

    // A drain is visible at the negedge before the edge that completes it
    always @(negedge Reloj) begin
        if (EscrituraValida === 1'b1 && EscrituraLista === 1'b1 && Reinicio === 1'b0) begin
            if (esperadas.size() == 0) begin
                chk("write_unexpected", {29'd0, EscrituraDir}, 32'hFFFF_FFFF);
            end else begin
                esc_t e;
                e = esperadas.pop_front();
                chk("write_dir", {29'd0, EscrituraDir}, {29'd0, e.dir});
                chk("write_dato", {16'd0, EscrituraDato}, {16'd0, e.dato});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tabla[15];

    initial begin
        tabla[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3'd3, 4'b1010, 1'b1, 16'h8000};
        tabla[1]  = '{OP_TEST, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'd0, 4'b0100, 1'b0, 16'h0000};
        tabla[2]  = '{OP_SL,   16'h8001, 16'h0000, 16'h0002, 1'b1, 3'd1, 4'b0001, 1'b1, 16'h0002};
        tabla[3]  = '{OP_RLC,  16'h4000, 16'h0000, 16'hFFFF, 1'b1, 3'd2, 4'b1000, 1'b1, 16'h8001};
        tabla[4]  = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 3'd4, 4'b0111, 1'b1, 16'h0000};
        tabla[5]  = '{OP_NOT,  16'h00FF, 16'h0000, 16'hFF00, 1'b0, 3'd5, 4'b1011, 1'b1, 16'hFF00};
        tabla[6]  = '{OP_NOT,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 3'd6, 4'b0111, 1'b1, 16'h0000};
        tabla[7]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 3'd7, 4'b0010, 1'b1, 16'h7FFF};
        tabla[8]  = '{OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 1'b0, 3'd0, 4'b1010, 1'b1, 16'h8000};
        tabla[9]  = '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 1'b0, 3'd1, 4'b0010, 1'b1, 16'h7FFF};
        tabla[10] = '{OP_RRC,  16'h0001, 16'h0000, 16'h5555, 1'b0, 3'd2, 4'b0111, 1'b1, 16'h0000};
        tabla[11] = '{OP_RRC,  16'h0000, 16'h0000, 16'h5555, 1'b0, 3'd3, 4'b1010, 1'b1, 16'h8000};
        tabla[12] = '{OP_MOV,  16'h1234, 16'h0000, 16'h1234, 1'b1, 3'd4, 4'b0010, 1'b1, 16'h1234};
        tabla[13] = '{OP_SR,   16'h0003, 16'h0000, 16'h0001, 1'b1, 3'd5, 4'b0011, 1'b1, 16'h0001};
        tabla[14] = '{OP_DEC,  16'h0001, 16'h0000, 16'h0000, 1'b0, 3'd6, 4'b0100, 1'b1, 16'h0000};

        Reinicio       = 1'b1;
        EscrituraLista = 1'b1;
        conducir(OP_MOV, '0, '0, '0, 1'b0, '0);
        EntradaValida  = 1'b0;
        repeat (2) @(posedge Reloj);
        #1;
        Reinicio = 1'b0;
        chk("reset_estado", {28'd0, Estado}, 32'd0);
        chk("reset_valida", {31'd0, EscrituraValida}, 32'd0);
        chk("reset_dir", {29'd0, EscrituraDir}, 32'd0);
        chk("reset_dato", {16'd0, EscrituraDato}, 32'd0);
        chk("reset_lista", {31'd0, EntradaLista}, 32'd1);

        // Back-to-back vectors with the bank always ready
        for (int i = 0; i < 15; i++) begin
            conducir(tabla[i].sel, tabla[i].a, tabla[i].b, tabla[i].r, tabla[i].cy, tabla[i].dst);
            if (tabla[i].wr) esperadas.push_back('{tabla[i].dst, tabla[i].dato});
            @(posedge Reloj);
            #1;
            chk($sformatf("vec%0d_estado", i), {28'd0, Estado}, {28'd0, tabla[i].est});
            chk($sformatf("vec%0d_valida", i), {31'd0, EscrituraValida}, {31'd0, tabla[i].wr});
        end
        EntradaValida = 1'b0;
        @(posedge Reloj);
        #1;

        // Stall: two ops offered while the bank is not ready
        EscrituraLista = 1'b0;
        conducir(OP_AND, 16'h00FF, 16'h00A5, 16'h00A5, 1'b0, 3'd6);
        esperadas.push_back('{3'd6, 16'h00A5});
        @(posedge Reloj);
        #1;
        chk("stall_estado1", {28'd0, Estado}, 32'b0000);
        conducir(OP_OR, 16'h8000, 16'h0000, 16'h8000, 1'b0, 3'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge Reloj);
            chk("stall_lista", {31'd0, EntradaLista}, 32'd0);
            chk("stall_dato", {16'd0, EscrituraDato}, 32'h0000_00A5);
            chk("stall_dir", {29'd0, EscrituraDir}, 32'd6);
            @(posedge Reloj);
            #1;
        end
        EscrituraLista = 1'b1;
        esperadas.push_back('{3'd7, 16'h8000});
        @(posedge Reloj);
        #1;
        EntradaValida = 1'b0;
        chk("stall_estado2", {28'd0, Estado}, 32'b1000);
        chk("stall_valida2", {31'd0, EscrituraValida}, 32'd1);
        chk("stall_dato2", {16'd0, EscrituraDato}, 32'h0000_8000);
        repeat (2) @(posedge Reloj);
        #1;
        chk("drained_valida", {31'd0, EscrituraValida}, 32'd0);

        // Reset while a write is stalled drops the entry
        EscrituraLista = 1'b0;
        conducir(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 3'd5);
        esperadas.push_back('{3'd5, 16'h0002});
        @(posedge Reloj);
        #1;
        EntradaValida = 1'b0;
        chk("prerst_valida", {31'd0, EscrituraValida}, 32'd1);
        Reinicio = 1'b1;
        void'(esperadas.pop_back());
        @(posedge Reloj);
        #1;
        Reinicio = 1'b0;
        chk("rst_stall_estado", {28'd0, Estado}, 32'd0);
        chk("rst_stall_valida", {31'd0, EscrituraValida}, 32'd0);
        chk("rst_stall_lista", {31'd0, EntradaLista}, 32'd1);
        EscrituraLista = 1'b1;
        repeat (3) @(posedge Reloj);
        #1;
        chk("queue_empty", esperadas.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
